// File: rtl/mdu_div.sv
// Iterative 32-bit divider feeding the HI/LO register: remainder to HI, quotient to LO.
// Define DIV_SIGNED_EN to honour signed_i; without it every divide is unsigned.
module mdu_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        annul_i,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIVZ = 2'd1;
    localparam logic [1:0] ST_ON   = 2'd2;
    localparam logic [1:0] ST_END  = 2'd3;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] dvd_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_n;
    logic [31:0] quo_n;
    logic [31:0] fin_hi;
    logic [31:0] fin_lo;
    logic        accept;

    assign accept = (state == ST_IDLE) && start_i && !annul_i && !rst;

`ifdef DIV_SIGNED_EN
    logic neg1;
    logic neg2;
    logic quo_neg_q;
    logic rem_neg_q;

    assign neg1   = signed_i & opdata1_i[31];
    assign neg2   = signed_i & opdata2_i[31];
    assign mag1   = neg1 ? -opdata1_i : opdata1_i;
    assign mag2   = neg2 ? -opdata2_i : opdata2_i;
    assign fin_lo = quo_neg_q ? -quo_n : quo_n;
    assign fin_hi = rem_neg_q ? -rem_n : rem_n;

    // Quotient takes the xor of signs, remainder follows the dividend.
    always_ff @(posedge clk) begin
        if (rst) begin
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (accept) begin
            quo_neg_q <= neg1 ^ neg2;
            rem_neg_q <= neg1;
        end
    end
`else
    logic unused_sign;

    assign unused_sign = signed_i;
    assign mag1        = opdata1_i;
    assign mag2        = opdata2_i;
    assign fin_lo      = quo_n;
    assign fin_hi      = rem_n;
`endif

    // One restoring step: shift in the next dividend bit, keep the difference if it fits.
    always_comb begin
        shifted = {rem_q, quo_q[31]};
        diff    = shifted - {1'b0, dvs_q};
        rem_n   = shifted[31:0];
        quo_n   = {quo_q[30:0], 1'b0};
        if (!diff[32]) begin
            rem_n = diff[31:0];
            quo_n = {quo_q[30:0], 1'b1};
        end
    end

    assign hi_we   = (state == ST_END) && !annul_i && !rst;
    assign lo_we   = hi_we;
    assign stall_o = accept || (state == ST_ON) || (state == ST_DIVZ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
            rem_q <= 32'd0;
            quo_q <= 32'd0;
            dvs_q <= 32'd0;
            dvd_q <= 32'd0;
            hi_o  <= 32'd0;
            lo_o  <= 32'd0;
        end else if (annul_i) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        cnt   <= 6'd0;
                        rem_q <= 32'd0;
                        quo_q <= mag1;
                        dvs_q <= mag2;
                        dvd_q <= opdata1_i;
                        state <= (opdata2_i == 32'd0) ? ST_DIVZ : ST_ON;
                    end
                end
                ST_DIVZ: begin
                    hi_o  <= dvd_q;
                    lo_o  <= 32'hFFFF_FFFF;
                    state <= ST_END;
                end
                ST_ON: begin
                    rem_q <= rem_n;
                    quo_q <= quo_n;
                    cnt   <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        hi_o  <= fin_hi;
                        lo_o  <= fin_lo;
                        state <= ST_END;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 SHALL declare clk  input  1  clock; all state changes on rising edge.
REQ-002 SHALL declare rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL declare start_i  input  1  divide request; sampled only in IDLE.
REQ-004 SHALL declare signed_i  input  1  1 = two's-complement operands (DIV), 0 = unsigned (DIVU).
REQ-005 SHALL declare opdata1_i  input  32  dividend.
REQ-006 SHALL declare opdata2_i  input  32  divisor.
REQ-007 SHALL declare annul_i  input  1  pipeline flush; abandons the current operation.
REQ-008 SHALL declare hi_we  output  1  HI write strobe toward the HI/LO register.
REQ-009 SHALL declare lo_we  output  1  LO write strobe toward the HI/LO register.
REQ-010 SHALL declare hi_o  output  32  remainder, written into HI.
REQ-011 SHALL declare lo_o  output  32  quotient, written into LO.
REQ-012 SHALL declare stall_o  output  1  pipeline stall request while the divide is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, DIVZERO, ON, END.
REQ-014 IDLE: start_i=1 and annul_i=0 -> latch operands and signed_i; divisor==0 -> DIVZERO, else -> ON.
REQ-015 ON SHALL run a radix-2 restoring divide on magnitudes, one quotient bit per cycle, with a 6-bit iteration counter; exactly 32 cycles in ON, then -> END.
REQ-016 DIVZERO SHALL last exactly one cycle, then -> END.
REQ-017 END SHALL assert hi_we=lo_we=1 for exactly that one cycle, then -> IDLE unconditionally.
REQ-018 Latency: with start sampled in cycle N, the strobes are high in cycle N+33 (normal) or cycle N+2 (divide by zero).
REQ-019 Signed mode: operands negated to magnitudes when negative; quotient sign = sign1 XOR sign2; remainder sign = dividend sign.
REQ-020 0x80000000 / 0xFFFFFFFF signed SHALL yield lo_o=0x80000000, hi_o=0 (wraps; no exception).
REQ-021 Divide by zero SHALL yield lo_o=0xFFFFFFFF, hi_o=original dividend (unmodified, any mode).
REQ-022 hi_o/lo_o SHALL hold the last result whenever hi_we/lo_we are low.
REQ-023 stall_o SHALL be 1 in DIVZERO and ON, and in the IDLE cycle in which start is accepted; 0 otherwise, including END.
REQ-024 start_i outside IDLE SHALL be ignored.
REQ-025 Operand changes after acceptance SHALL NOT affect the result.
REQ-026 annul_i=1 in any state SHALL force IDLE at the next edge with no strobe; annul in END suppresses that END's strobe.
REQ-027 annul_i and start_i both high in IDLE: annul wins and nothing is accepted.

Reset
REQ-028 rst=1 SHALL set state IDLE, counter 0, hi_o=lo_o=0, hi_we=lo_we=0, stall_o=0.
REQ-029 rst has priority over annul and start.
REQ-030 rst during ON or END SHALL discard the operation with no strobe.

Configuration
REQ-031 Macro DIV_SIGNED_EN defined: signed_i honoured per REQ-019/020.
REQ-032 DIV_SIGNED_EN undefined: the sign-handling logic is omitted, signed_i is ignored, and all divides are unsigned; latencies are unchanged.

Verification
REQ-033 Unsigned 100/7, start in cycle N -> cycle N+33: lo_o=0x0000000E, hi_o=0x00000002, strobes high for one cycle.
REQ-034 Signed 0xFFFFFFF9/0x00000002 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-035 Signed 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0x00000000.
REQ-036 5/0, start in cycle N -> cycle N+2: lo_o=0xFFFFFFFF, hi_o=0x00000005; stall_o high in cycles N and N+1 only.
REQ-037 annul_i in cycle N+10 -> no strobe, IDLE in cycle N+11; a new start in N+11 is accepted and completes in N+44.
REQ-038 rst in cycle N+20 -> all outputs 0 next cycle, no strobe, stall_o=0.
